// File: rtl/udp_rx_demux.sv
// udp_rx_demux: GMII receive-side UDP parser and port demultiplexer.
// Validates Ethernet II / IPv4 / UDP headers on the fly, matches the UDP
// destination port against PORT_LIST and packs the payload into an
// AXI-Stream with tkeep, tdest (port index) and tuser (corrupt packet).
module udp_rx_demux #(
  parameter int                        DATA_WIDTH = 32,
  parameter int                        NUM_PORTS  = 4,
  parameter logic [NUM_PORTS*16-1:0]   PORT_LIST  = {16'h1390, 16'h138F, 16'h138E, 16'h138D},
  parameter int                        CHECK_IP   = 1,
  localparam int                       KEEP_W     = DATA_WIDTH / 8,
  localparam int                       DEST_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  input  logic [47:0]           mac_d_addr,
  input  logic [31:0]           ip_d_addr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0]     m_axis_tkeep,
  output logic [DEST_W-1:0]     m_axis_tdest,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  pkt_ok,
  output logic                  pkt_drop,
  output logic                  pkt_err
);

  // Lane counter must be able to hold KEEP_W itself (a full word).
  localparam int LANE_W = $clog2(KEEP_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TERM,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic                    dv_prev_q, dv_prev_d;
  logic [10:0]             cnt_q, cnt_d;
  logic                    mac_ok_q, mac_ok_d;
  logic                    bc_ok_q, bc_ok_d;
  logic [7:0]              port_hi_q, port_hi_d;
  logic [7:0]              len_hi_q, len_hi_d;
  logic [10:0]             rem_q, rem_d;
  logic [DEST_W-1:0]       dest_q, dest_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]       tkeep_q, tkeep_d;
  logic [DEST_W-1:0]       tdest_q, tdest_d;
  logic                    tuser_q, tuser_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ok_q, ok_d;
  logic                    drop_q, drop_d;
  logic                    err_q, err_d;

  // Header comparison helpers.
  logic [7:0]              mac_bytes [0:5];
  logic [7:0]              ip_bytes  [0:3];
  logic [1:0]              ip_idx;
  logic [NUM_PORTS-1:0]    port_hit;
  logic                    port_any;
  logic [DEST_W-1:0]       hit_idx;
  logic [15:0]             udp_len;
  logic                    frame_start;

  // Per-cycle working values.
  logic                    hdr_fail;
  logic                    mac_hit;
  logic                    bc_hit;
  logic                    last_byte;
  logic                    can_load;
  logic                    load;
  logic [LANE_W-1:0]       n_fill;
  logic [DATA_WIDTH-1:0]   acc_base;
  logic [DATA_WIDTH-1:0]   word_v;
  logic [DATA_WIDTH-1:0]   issue_data;
  logic [KEEP_W-1:0]       issue_keep;
  logic                    issue_last;
  logic                    issue_user;

  // MAC and IP addresses are transmitted most significant byte first.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mac
      assign mac_bytes[gi] = mac_d_addr[8*(5-gi) +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_ip
      assign ip_bytes[gi] = ip_d_addr[8*(3-gi) +: 8];
    end
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_hit[gi] = ({port_hi_q, data_in} == PORT_LIST[16*gi +: 16]);
    end
  endgenerate

  // Bytes 30..33 carry the destination IP; low counter bits minus 2 give the index.
  assign ip_idx      = cnt_q[1:0] - 2'd2;
  assign udp_len     = {len_hi_q, data_in};
  assign frame_start = data_valid & ~dv_prev_q;
  assign can_load    = ~tvalid_q | m_axis_tready;
  // A fresh word starts from zero so unused upper lanes read as 0.
  assign acc_base    = (lane_q == '0) ? '0 : acc_q;

  // Number of filled lanes to a contiguous keep mask.
  function automatic logic [KEEP_W-1:0] keep_of(input logic [LANE_W-1:0] n);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (i < int'(n)) k[i] = 1'b1;
    end
    return k;
  endfunction

  // Priority-encode the port match: on duplicates the lowest index wins.
  always_comb begin
    port_any = |port_hit;
    hit_idx  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_hit[i]) hit_idx = DEST_W'(i);
    end
  end

  // Next-state, header checks, lane packing and output beat register.
  always_comb begin
    state_d    = state_q;
    dv_prev_d  = data_valid;
    cnt_d      = cnt_q;
    mac_ok_d   = mac_ok_q;
    bc_ok_d    = bc_ok_q;
    port_hi_d  = port_hi_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    dest_d     = dest_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    ovf_d      = ovf_q;
    ok_d       = 1'b0;
    drop_d     = 1'b0;
    err_d      = 1'b0;
    hdr_fail   = 1'b0;
    mac_hit    = 1'b0;
    bc_hit     = 1'b0;
    last_byte  = 1'b0;
    load       = 1'b0;
    n_fill     = '0;
    word_v     = '0;
    issue_data = '0;
    issue_keep = '0;
    issue_last = 1'b0;
    issue_user = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          cnt_d    = 11'd1;
          ovf_d    = 1'b0;
          lane_d   = '0;
          mac_hit  = (data_in == mac_bytes[0]);
          bc_hit   = (data_in == 8'hFF);
          mac_ok_d = mac_hit;
          bc_ok_d  = bc_hit;
          if (!(mac_hit || bc_hit)) begin
            drop_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = HEADER;
          end
        end
      end

      HEADER: begin
        if (!data_valid) begin
          drop_d  = 1'b1;
          state_d = DRAIN;
        end else begin
          if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
          if (cnt_q < 11'd6) begin
            mac_hit  = mac_ok_q && (data_in == mac_bytes[cnt_q[2:0]]);
            bc_hit   = bc_ok_q && (data_in == 8'hFF);
            mac_ok_d = mac_hit;
            bc_ok_d  = bc_hit;
            hdr_fail = !(mac_hit || bc_hit);
          end
          if ((CHECK_IP != 0) && (cnt_q >= 11'd30) && (cnt_q <= 11'd33) &&
              (data_in != ip_bytes[ip_idx])) begin
            hdr_fail = 1'b1;
          end
          case (cnt_q)
            11'd12: if (data_in != 8'h08) hdr_fail = 1'b1;
            11'd13: if (data_in != 8'h00) hdr_fail = 1'b1;
            11'd14: if (data_in != 8'h45) hdr_fail = 1'b1;
            11'd23: if (data_in != 8'h11) hdr_fail = 1'b1;
            11'd36: port_hi_d = data_in;
            11'd37: begin
              if (!port_any) hdr_fail = 1'b1;
              else dest_d = hit_idx;
            end
            11'd38: len_hi_d = data_in;
            11'd39: begin
              if (udp_len < 16'd9) hdr_fail = 1'b1;
              rem_d = udp_len[10:0] - 11'd8;
            end
            default: ;
          endcase
          if (hdr_fail) begin
            drop_d  = 1'b1;
            state_d = DRAIN;
          end else if (cnt_q == 11'd41) begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (!data_valid) begin
          // Truncated: flush whatever is pending as a corrupt tlast beat.
          issue_data = acc_base;
          issue_keep = keep_of(lane_q);
          issue_last = 1'b1;
          issue_user = 1'b1;
          lane_d     = '0;
          if (!ovf_q && can_load) begin
            load    = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ovf_d   = 1'b1;
            state_d = TERM;
          end
        end else begin
          word_v = acc_base;
          for (int i = 0; i < KEEP_W; i++) begin
            if (lane_q == LANE_W'(i)) word_v[8*i +: 8] = data_in;
          end
          n_fill    = lane_q + 1'b1;
          last_byte = (rem_q <= 11'd1);
          rem_d     = rem_q - 11'd1;
          acc_d     = word_v;
          lane_d    = n_fill;
          if (last_byte || (lane_q == LANE_W'(KEEP_W - 1))) begin
            lane_d     = '0;
            issue_data = word_v;
            issue_keep = keep_of(n_fill);
            issue_last = last_byte;
            if (!ovf_q && can_load) load = 1'b1;
            else ovf_d = 1'b1;
          end
          if (last_byte) begin
            if (ovf_q || !can_load) begin
              state_d = TERM;
            end else begin
              ok_d    = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end

      TERM: begin
        // Words were lost: close the packet with an empty corrupt beat.
        if (can_load) begin
          issue_last = 1'b1;
          issue_user = 1'b1;
          load       = 1'b1;
          err_d      = 1'b1;
          state_d    = data_valid ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        if (!data_valid) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tdest_d  = tdest_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = issue_data;
      tkeep_d  = issue_keep;
      tdest_d  = dest_q;
      tuser_d  = issue_user;
      tlast_d  = issue_last;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      dv_prev_q <= 1'b1;
      cnt_q     <= '0;
      mac_ok_q  <= 1'b0;
      bc_ok_q   <= 1'b0;
      port_hi_q <= '0;
      len_hi_q  <= '0;
      rem_q     <= '0;
      dest_q    <= '0;
      acc_q     <= '0;
      lane_q    <= '0;
      ovf_q     <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tdest_q   <= '0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      ok_q      <= 1'b0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dv_prev_q <= dv_prev_d;
      cnt_q     <= cnt_d;
      mac_ok_q  <= mac_ok_d;
      bc_ok_q   <= bc_ok_d;
      port_hi_q <= port_hi_d;
      len_hi_q  <= len_hi_d;
      rem_q     <= rem_d;
      dest_q    <= dest_d;
      acc_q     <= acc_d;
      lane_q    <= lane_d;
      ovf_q     <= ovf_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tdest_q   <= tdest_d;
      tuser_q   <= tuser_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      ok_q      <= ok_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign pkt_ok        = ok_q;
  assign pkt_drop      = drop_q;
  assign pkt_err       = err_q;

endmodule

// File: tb/tb_udp_rx_demux.sv
// Directed bench for udp_rx_demux: four instances (32, 8, 16, 64-bit
// outputs, the last with 8 ports and a duplicated entry) share one byte
// stream; beats and status pulses are logged and checked after each frame.
module tb_udp_rx_demux;

  localparam logic [47:0] MAC  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IP   = 32'hC0A8010A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       rdy32, rdy8, rdy16, rdy64;

  logic [31:0] d32; logic [3:0] k32; logic [1:0] t32;
  logic u32, l32, v32, ok32, dr32, er32;
  logic [7:0]  d8;  logic [0:0] k8;  logic [1:0] t8;
  logic u8, l8, v8, ok8, dr8, er8;
  logic [15:0] d16; logic [1:0] k16; logic [1:0] t16;
  logic u16, l16, v16, ok16, dr16, er16;
  logic [63:0] d64; logic [7:0] k64; logic [2:0] t64;
  logic u64, l64, v64, ok64, dr64, er64;

  udp_rx_demux #(.DATA_WIDTH(32)) dut32 (
    .aclk(clk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .mac_d_addr(MAC), .ip_d_addr(IP),
    .m_axis_tdata(d32), .m_axis_tkeep(k32), .m_axis_tdest(t32), .m_axis_tuser(u32),
    .m_axis_tlast(l32), .m_axis_tvalid(v32), .m_axis_tready(rdy32),
    .pkt_ok(ok32), .pkt_drop(dr32), .pkt_err(er32));

  udp_rx_demux #(.DATA_WIDTH(8)) dut8 (
    .aclk(clk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .mac_d_addr(MAC), .ip_d_addr(IP),
    .m_axis_tdata(d8), .m_axis_tkeep(k8), .m_axis_tdest(t8), .m_axis_tuser(u8),
    .m_axis_tlast(l8), .m_axis_tvalid(v8), .m_axis_tready(rdy8),
    .pkt_ok(ok8), .pkt_drop(dr8), .pkt_err(er8));

  udp_rx_demux #(.DATA_WIDTH(16)) dut16 (
    .aclk(clk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .mac_d_addr(MAC), .ip_d_addr(IP),
    .m_axis_tdata(d16), .m_axis_tkeep(k16), .m_axis_tdest(t16), .m_axis_tuser(u16),
    .m_axis_tlast(l16), .m_axis_tvalid(v16), .m_axis_tready(rdy16),
    .pkt_ok(ok16), .pkt_drop(dr16), .pkt_err(er16));

  udp_rx_demux #(
    .DATA_WIDTH(64), .NUM_PORTS(8),
    .PORT_LIST({16'h4444, 16'h3333, 16'h2000, 16'h2222,
                16'h1111, 16'h2000, 16'h138E, 16'h138D})
  ) dut64 (
    .aclk(clk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .mac_d_addr(MAC), .ip_d_addr(IP),
    .m_axis_tdata(d64), .m_axis_tkeep(k64), .m_axis_tdest(t64), .m_axis_tuser(u64),
    .m_axis_tlast(l64), .m_axis_tvalid(v64), .m_axis_tready(rdy64),
    .pkt_ok(ok64), .pkt_drop(dr64), .pkt_err(er64));

  // Beat and pulse logs, sampled mid-cycle.
  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  logic        q_user[$];
  logic [1:0]  q_dest[$];
  int n_ok32 = 0, n_drop32 = 0, n_err32 = 0;
  int nb8 = 0, nb16 = 0, nb64 = 0;
  logic [0:0]  lk8;
  logic [1:0]  lk16;
  logic [15:0] ld16;
  logic [7:0]  lk64;
  logic [2:0]  ldst64;
  logic [63:0] q_data64[$];

  always @(negedge clk) begin
    if (v32 && rdy32) begin
      q_data.push_back(d32); q_keep.push_back(k32); q_last.push_back(l32);
      q_user.push_back(u32); q_dest.push_back(t32);
    end
    if (ok32) n_ok32 = n_ok32 + 1;
    if (dr32) n_drop32 = n_drop32 + 1;
    if (er32) n_err32 = n_err32 + 1;
    if (v8 && rdy8) begin nb8 = nb8 + 1; lk8 = k8; end
    if (v16 && rdy16) begin nb16 = nb16 + 1; lk16 = k16; ld16 = d16; end
    if (v64 && rdy64) begin
      nb64 = nb64 + 1; lk64 = k64; ldst64 = t64; q_data64.push_back(d64);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] frm [0:255];
  int flen;

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] vihl,
                       input logic [7:0] proto, input logic [15:0] dport, input logic [15:0] ulen,
                       input int npay);
    logic [15:0] tot;
    int end_pay;
    tot = 16'd20 + ulen;
    for (int i = 0; i < 6; i++) frm[i] = dmac[8*(5-i) +: 8];
    frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00; frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'h01;
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[14] = vihl; frm[15] = 8'h00; frm[16] = tot[15:8]; frm[17] = tot[7:0];
    for (int i = 18; i < 22; i++) frm[i] = 8'h00;
    frm[22] = 8'h40; frm[23] = proto; frm[24] = 8'h00; frm[25] = 8'h00;
    frm[26] = 8'hC0; frm[27] = 8'hA8; frm[28] = 8'h01; frm[29] = 8'h01;
    for (int i = 0; i < 4; i++) frm[30+i] = IP[8*(3-i) +: 8];
    frm[34] = 8'h04; frm[35] = 8'hD2; frm[36] = dport[15:8]; frm[37] = dport[7:0];
    frm[38] = ulen[15:8]; frm[39] = ulen[7:0]; frm[40] = 8'h00; frm[41] = 8'h00;
    for (int i = 0; i < npay; i++) frm[42+i] = 8'(i + 1);
    end_pay = 42 + npay;
    for (int i = end_pay; i < 60; i++) frm[i] = 8'hEE;
    if (end_pay < 60) end_pay = 60;
    for (int i = 0; i < 4; i++) frm[end_pay+i] = 8'hAA;
    flen = end_pay + 4;
  endtask

  // Drive nbytes of frm; reset is held for two bytes starting at rst_at.
  task automatic send(input int nbytes, input int rst_at);
    $display("tx frame: %0d bytes, port 0x%02h%02h, reset_at %0d", nbytes, frm[36], frm[37], rst_at);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      data_valid = 1'b1;
      data_in    = frm[i];
      areset     = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 2);
    end
    @(posedge clk); #1;
    data_valid = 1'b0; data_in = 8'h00; areset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, o0, d0, e0, n8, n16, n64;
    logic [15:0] bad_et [0:3];
    logic [7:0]  bad_ihl [0:3];
    logic [7:0]  bad_pr [0:3];
    logic [15:0] bad_pt [0:3];
    bad_et  = '{16'h0806, 16'h0800, 16'h0800, 16'h0800};
    bad_ihl = '{8'h45, 8'h45, 8'h45, 8'h46};
    bad_pr  = '{8'h11, 8'h06, 8'h11, 8'h11};
    bad_pt  = '{16'h138E, 16'h138E, 16'h1234, 16'h138E};

    areset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    rdy32 = 1'b1; rdy8 = 1'b1; rdy16 = 1'b1; rdy64 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_axis", {60'd0, v32, l32, u32, 1'b0}, 64'd0);
    check("reset_tdata_keep_dest", {26'd0, d32, k32, t32}, 64'd0);
    check("reset_pulses", {61'd0, ok32, dr32, er32}, 64'd0);
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Header rejects: ethertype, protocol, port, IHL.
    for (int r = 0; r < 4; r++) begin
      b0 = q_data.size(); d0 = n_drop32;
      build(BCST, bad_et[r], bad_ihl[r], bad_pr[r], bad_pt[r], 16'd14, 6);
      send(flen, -1);
      check($sformatf("reject%0d_drop", r), 64'(n_drop32 - d0), 64'd1);
      check($sformatf("reject%0d_beats", r), 64'(q_data.size() - b0), 64'd0);
    end

    // Matched frame, broadcast MAC, port index 1.
    b0 = q_data.size(); o0 = n_ok32; d0 = n_drop32;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd14, 6);
    send(flen, -1);
    check("match_beats", 64'(q_data.size() - b0), 64'd2);
    check("match_b1_data", 64'(q_data[b0]), 64'h04030201);
    check("match_b1_keep_last", {59'd0, q_keep[b0], q_last[b0]}, {59'd0, 4'hF, 1'b0});
    check("match_b2_data", 64'(q_data[b0+1]), 64'h00000605);
    check("match_b2_keep", 64'(q_keep[b0+1]), 64'h3);
    check("match_b2_last_user", {62'd0, q_last[b0+1], q_user[b0+1]}, {62'd0, 1'b1, 1'b0});
    check("match_tdest", 64'(q_dest[b0+1]), 64'd1);
    check("match_ok", 64'(n_ok32 - o0), 64'd1);
    check("match_nodrop", 64'(n_drop32 - d0), 64'd0);

    // Backpressure overflow: 64-byte payload with tready low throughout.
    rdy32 = 1'b0;
    b0 = q_data.size(); o0 = n_ok32; e0 = n_err32;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd72, 64);
    send(flen, -1);
    check("ovf_held_valid", {63'd0, v32}, 64'd1);
    check("ovf_held_data", 64'(d32), 64'h04030201);
    check("ovf_no_accept", 64'(q_data.size() - b0), 64'd0);
    rdy32 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ovf_beats", 64'(q_data.size() - b0), 64'd2);
    check("ovf_b1_data", 64'(q_data[b0]), 64'h04030201);
    check("ovf_b1_keep_last", {59'd0, q_keep[b0], q_last[b0]}, {59'd0, 4'hF, 1'b0});
    check("ovf_term_keep", 64'(q_keep[b0+1]), 64'h0);
    check("ovf_term_last_user", {62'd0, q_last[b0+1], q_user[b0+1]}, 64'h3);
    check("ovf_err", 64'(n_err32 - e0), 64'd1);
    check("ovf_no_ok", 64'(n_ok32 - o0), 64'd0);

    // Truncation after 5 of 10 payload bytes, unicast MAC.
    b0 = q_data.size(); e0 = n_err32; o0 = n_ok32;
    build(MAC, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd18, 10);
    send(47, -1);
    check("trunc_beats", 64'(q_data.size() - b0), 64'd2);
    check("trunc_b1_data", 64'(q_data[b0]), 64'h04030201);
    check("trunc_b2_data", 64'(q_data[b0+1]), 64'h00000005);
    check("trunc_b2_keep", 64'(q_keep[b0+1]), 64'h1);
    check("trunc_b2_last_user", {62'd0, q_last[b0+1], q_user[b0+1]}, 64'h3);
    check("trunc_err", 64'(n_err32 - e0), 64'd1);
    check("trunc_no_ok", 64'(n_ok32 - o0), 64'd0);

    // Widths: 9-byte payload on every instance.
    b0 = q_data.size(); n8 = nb8; n16 = nb16; n64 = nb64;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd17, 9);
    send(flen, -1);
    check("w32_beats", 64'(q_data.size() - b0), 64'd3);
    check("w32_last_keep", 64'(q_keep[b0+2]), 64'h1);
    check("w8_beats", 64'(nb8 - n8), 64'd9);
    check("w8_last_keep", 64'(lk8), 64'h1);
    check("w16_beats", 64'(nb16 - n16), 64'd5);
    check("w16_last_keep", 64'(lk16), 64'h1);
    check("w16_last_data", 64'(ld16), 64'h0009);
    check("w64_beats", 64'(nb64 - n64), 64'd2);
    check("w64_b1_data", q_data64[n64], 64'h0807060504030201);
    check("w64_last_keep", 64'(lk64), 64'h01);
    check("w64_tdest", 64'(ldst64), 64'd1);

    // Duplicate port 0x2000 at index 2 and 5 on the 8-port instance.
    n64 = nb64; d0 = n_drop32;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h2000, 16'd17, 9);
    send(flen, -1);
    check("dup_beats", 64'(nb64 - n64), 64'd2);
    check("dup_tdest", 64'(ldst64), 64'd2);
    check("dup_w32_drop", 64'(n_drop32 - d0), 64'd1);

    // Reset mid-payload, released with data_valid still high.
    b0 = q_data.size(); o0 = n_ok32; d0 = n_drop32; e0 = n_err32;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd28, 20);
    send(flen, 44);
    check("rst_no_beats", 64'(q_data.size() - b0), 64'd0);
    check("rst_outputs", {23'd0, v32, l32, u32, d32, k32, t32}, 64'd0);
    check("rst_no_pulses", 64'((n_ok32 - o0) + (n_drop32 - d0) + (n_err32 - e0)), 64'd0);

    // Next frame after reset is received normally.
    b0 = q_data.size(); o0 = n_ok32;
    build(BCST, 16'h0800, 8'h45, 8'h11, 16'h138E, 16'd14, 6);
    send(flen, -1);
    check("post_rst_beats", 64'(q_data.size() - b0), 64'd2);
    check("post_rst_b2_data", 64'(q_data[b0+1]), 64'h00000605);
    check("post_rst_ok", 64'(n_ok32 - o0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
